ltpi_dch_req_scheduler: RTL and testbench
=========================================

# ltpi_dch_req_scheduler

Round-robin scheduler that shares the single LTPI data channel between up to NUM_REQ local requesters (CSR bridge, SMBus relay, OEM logic) on the BMC or SCM side. It grants one requester at a time, tags and issues the request to the data-channel framer, and waits for the matching response. It routes the response back to the owner, or returns a timeout error, then re-arbitrates. Exactly one transaction is outstanding on the link at any time.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- TIMEOUT_CYC, 1024: maximum wait cycles for a response, at least 2
- clk  in  1  block clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- req_cmd  in  NUM_REQ×4  command (read/write encoding from package)
- req_addr  in  NUM_REQ×32  address
- req_wdata  in  NUM_REQ×32  write data
- req_be  in  NUM_REQ×4  byte enables
- dch_req_valid  out  1  request to framer
- dch_req_ready  in  1  framer accept
- dch_req_cmd / dch_req_addr / dch_req_wdata / dch_req_be  out  4/32/32/4  captured payload
- dch_req_tag  out  8  transaction tag
- dch_resp_valid  in  1  response from deframer, single-cycle
- dch_resp_tag  in  8  response tag
- dch_resp_rdata  in  32  read data
- dch_resp_status  in  4  link status
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
- rsp_rdata  out  32  response data, shared by all requesters
- rsp_status  out  4  response status, shared by all requesters
- stale_cnt  out  16  dropped-response counter, saturating
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SEND, WAIT.
- IDLE:
  - req_ready[g] is combinational, where g is the first requester with req_valid set, searching from rr_ptr upward with wrap.
  - On handshake, capture the payload and go to SEND.
  - rr_ptr updates to (g+1) mod NUM_REQ.
- SEND:
  - dch_req_valid is held at 1 with stable payload and tag.
  - On dch_req_ready, go to WAIT and clear the timeout counter.
  - No timeout applies in SEND; link backpressure is unbounded.
- WAIT:
  - The timeout counter increments each cycle.
  - dch_resp_valid with tag equal to the current tag: register rdata and status, pulse rsp_valid[owner] on the next cycle, go to IDLE.
  - Counter reaches TIMEOUT_CYC-1 with no match: rsp_valid[owner] on the next cycle, rsp_status = STS_TIMEOUT (4'hF), rsp_rdata = 0, go to IDLE.
- Tag:
  - Increments by 1 at each dch request handshake, wrapping 8'hFF→8'h00.
  - dch_req_tag shows the tag of the captured transaction.
- Stale responses: dch_resp_valid outside WAIT, or with a mismatched tag, is dropped and increments stale_cnt, which saturates at 16'hFFFF.
- Reset (asynchronous, mid-transaction allowed):
  - State returns to IDLE; the in-flight transaction is abandoned with no rsp_valid.
  - Outputs:
    - rsp_valid = 0
    - dch_req_valid = 0
    - rsp_rdata = 0
    - rsp_status = 0
    - dch payload = 0
    - stale_cnt = 0
    - busy = 0
    - req_ready = 0
  - tag = 0, rr_ptr = 0.

## Timing
- Grant to dch_req_valid: the handshake in IDLE at cycle N gives dch_req_valid = 1 at cycle N+1.
- Response to strobe: a matching dch_resp_valid at cycle M gives rsp_valid at M+1; the FSM is in IDLE at M+1, so a new grant may coincide with rsp_valid.
- Matching response in the same cycle as timeout expiry: the response wins and status is the link status.
- A matching response in the same cycle as the SEND handshake is impossible by protocol; it is treated as stale.
- Minimum transaction: 3 cycles (grant, send accepted, response).
- req_ready is 0 in SEND and WAIT.

## Structure
- ltpi_dch_pkg holds:
  - cmd encodings (CMD_RD=4'h0, CMD_WR=4'h1)
  - status codes (STS_OK=4'h0, STS_TIMEOUT=4'hF)
  - the state enum
  - a request payload struct
- Sub-module ltpi_rr_arbiter (parameter N): combinational pick from req vector and pointer, outputs one-hot grant and index.
- Target size: 200–300 lines of RTL.

## Test plan
- Single read, req 0: framer ready immediately, response tag 0x00 with rdata 0xDEADBEEF and status 0 arriving 5 cycles later → rsp_valid[0] for one cycle with rdata 0xDEADBEEF, status 0; next tag is 0x01.
- All four requesters valid continuously, immediate responses → grant order 0,1,2,3,0; each rsp_valid one-hot to the correct owner.
- No response, TIMEOUT_CYC=16 → rsp_valid[owner] 16 cycles after entering WAIT, status 4'hF, rdata 0; busy drops.
- Stale responses:
  - Response with tag 0x05 while waiting on 0x04 → ignored, stale_cnt = 1.
  - A later correct 0x04 completes the transaction.
  - A response in IDLE also increments stale_cnt.
- 256 back-to-back transactions → tag wraps 0xFF→0x00 and all complete.
- reset_n asserted in WAIT:
  - All outputs are 0 immediately.
  - The late response after release counts as stale.
  - The next grant starts at requester 0 with tag 0x00.

Source files
------------

// File: rtl/ltpi_dch_pkg.sv
// Shared encodings, FSM state type and request payload layout for the LTPI
// data-channel request scheduler.
package ltpi_dch_pkg;

   localparam logic [3:0] CMD_RD      = 4'h0;
   localparam logic [3:0] CMD_WR      = 4'h1;

   localparam logic [3:0] STS_OK      = 4'h0;
   localparam logic [3:0] STS_TIMEOUT = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } dch_req_t;

endpackage

// File: rtl/ltpi_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or above ptr,
// wrapping, returned both one-hot and as an index.
module ltpi_rr_arbiter #(
   parameter int  N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && req[(int'(ptr) + i) % N]) begin
            any                         = 1'b1;
            grant[(int'(ptr) + i) % N]  = 1'b1;
            idx                         = IW'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/ltpi_dch_req_scheduler.sv
// Shares the single LTPI data channel among NUM_REQ requesters: round-robin
// grant, tagged issue to the framer, then response routing or timeout.
module ltpi_dch_req_scheduler
   import ltpi_dch_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*4-1:0] req_cmd,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0] req_wdata,
   input  logic [NUM_REQ*4-1:0] req_be,
   output logic                 dch_req_valid,
   input  logic                 dch_req_ready,
   output logic [3:0]           dch_req_cmd,
   output logic [31:0]          dch_req_addr,
   output logic [31:0]          dch_req_wdata,
   output logic [3:0]           dch_req_be,
   output logic [7:0]           dch_req_tag,
   input  logic                 dch_resp_valid,
   input  logic [7:0]           dch_resp_tag,
   input  logic [31:0]          dch_resp_rdata,
   input  logic [3:0]           dch_resp_status,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [31:0]          rsp_rdata,
   output logic [3:0]           rsp_status,
   output logic [15:0]          stale_cnt,
   output logic                 busy
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_e               state_q, state_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]        owner_q, owner_d;
   dch_req_t             pay_q, pay_d;
   logic [7:0]           cur_tag_q, cur_tag_d;
   logic [7:0]           nxt_tag_q, nxt_tag_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [31:0]          rsp_rdata_q, rsp_rdata_d;
   logic [3:0]           rsp_status_q, rsp_status_d;
   logic [15:0]          stale_q, stale_d;

   logic [NUM_REQ-1:0]   grant;
   logic [IW-1:0]        gidx;
   logic                 gany;
   logic                 resp_match;
   dch_req_t             req_pay;

   ltpi_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   // Ready must read low while reset is held, even though IDLE is the reset state.
   assign req_ready     = (reset_n && state_q == ST_IDLE) ? grant : '0;
   assign busy          = (state_q != ST_IDLE);
   assign dch_req_valid = (state_q == ST_SEND);
   assign dch_req_cmd   = pay_q.cmd;
   assign dch_req_addr  = pay_q.addr;
   assign dch_req_wdata = pay_q.wdata;
   assign dch_req_be    = pay_q.be;
   assign dch_req_tag   = cur_tag_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_status    = rsp_status_q;
   assign stale_cnt     = stale_q;

   always_comb begin
      req_pay.cmd   = req_cmd[int'(gidx)*4 +: 4];
      req_pay.addr  = req_addr[int'(gidx)*32 +: 32];
      req_pay.wdata = req_wdata[int'(gidx)*32 +: 32];
      req_pay.be    = req_be[int'(gidx)*4 +: 4];
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      pay_d        = pay_q;
      cur_tag_d    = cur_tag_q;
      nxt_tag_d    = nxt_tag_q;
      tmo_d        = tmo_q;
      rsp_valid_d  = '0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_status_d = rsp_status_q;
      stale_d      = stale_q;

      // Only a WAIT-state response carrying the outstanding tag is accepted.
      resp_match = dch_resp_valid && (state_q == ST_WAIT) && (dch_resp_tag == cur_tag_q);
      if (dch_resp_valid && !resp_match && stale_q != 16'hFFFF) begin
         stale_d = stale_q + 16'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (gany) begin
               pay_d     = req_pay;
               owner_d   = gidx;
               cur_tag_d = nxt_tag_q;
               rr_ptr_d  = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (dch_req_ready) begin
               nxt_tag_d = nxt_tag_q + 8'd1;
               tmo_d     = '0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            tmo_d = tmo_q + 1'b1;
            if (resp_match) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_rdata_d          = dch_resp_rdata;
               rsp_status_d         = dch_resp_status;
               state_d              = ST_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_rdata_d          = '0;
               rsp_status_d         = STS_TIMEOUT;
               state_d              = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         pay_q        <= '{cmd: CMD_RD, addr: '0, wdata: '0, be: '0};
         cur_tag_q    <= '0;
         nxt_tag_q    <= '0;
         tmo_q        <= '0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
         rsp_status_q <= STS_OK;
         stale_q      <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         pay_q        <= pay_d;
         cur_tag_q    <= cur_tag_d;
         nxt_tag_q    <= nxt_tag_d;
         tmo_q        <= tmo_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_status_q <= rsp_status_d;
         stale_q      <= stale_d;
      end
   end

endmodule

// File: tb/tb_ltpi_dch_req_scheduler.sv
// Bench for ltpi_dch_req_scheduler: directed transaction table, hand-written
// reset/stale/wrap sequences, and a randomized run against a transaction model.
module tb_ltpi_dch_req_scheduler;

   localparam int NR  = 4;
   localparam int TMO = 16;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*4-1:0] req_cmd;
   logic [NR*32-1:0] req_addr;
   logic [NR*32-1:0] req_wdata;
   logic [NR*4-1:0] req_be;
   logic            dch_req_valid;
   logic            dch_req_ready;
   logic [3:0]      dch_req_cmd;
   logic [31:0]     dch_req_addr;
   logic [31:0]     dch_req_wdata;
   logic [3:0]      dch_req_be;
   logic [7:0]      dch_req_tag;
   logic            dch_resp_valid;
   logic [7:0]      dch_resp_tag;
   logic [31:0]     dch_resp_rdata;
   logic [3:0]      dch_resp_status;
   logic [NR-1:0]   rsp_valid;
   logic [31:0]     rsp_rdata;
   logic [3:0]      rsp_status;
   logic [15:0]     stale_cnt;
   logic            busy;

   logic [3:0]  p_cmd   [NR];
   logic [31:0] p_addr  [NR];
   logic [31:0] p_wdata [NR];
   logic [3:0]  p_be    [NR];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         req_cmd[i*4 +: 4]    = p_cmd[i];
         req_addr[i*32 +: 32] = p_addr[i];
         req_wdata[i*32 +: 32] = p_wdata[i];
         req_be[i*4 +: 4]     = p_be[i];
      end
   end

   ltpi_dch_req_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .dch_req_valid(dch_req_valid), .dch_req_ready(dch_req_ready),
      .dch_req_cmd(dch_req_cmd), .dch_req_addr(dch_req_addr),
      .dch_req_wdata(dch_req_wdata), .dch_req_be(dch_req_be), .dch_req_tag(dch_req_tag),
      .dch_resp_valid(dch_resp_valid), .dch_resp_tag(dch_resp_tag),
      .dch_resp_rdata(dch_resp_rdata), .dch_resp_status(dch_resp_status),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
      .stale_cnt(stale_cnt), .busy(busy)
   );

   typedef struct {
      logic [3:0]  mask;
      int          delay;
      int          stale_at;
      bit          send_resp;
      logic [31:0] rdata;
      logic [3:0]  status;
      int          owner;
      logic [7:0]  tag;
      logic [3:0]  exp_st;
      logic [31:0] exp_rd;
      int          exp_stale;
   } vec_t;

   vec_t vt [12];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string nm);
      check({nm, "_rsp_valid"}, 32'(rsp_valid), 0);
      check({nm, "_dch_valid"}, 32'(dch_req_valid), 0);
      check({nm, "_rsp_rdata"}, rsp_rdata, 0);
      check({nm, "_rsp_status"}, 32'(rsp_status), 0);
      check({nm, "_dch_cmd"}, 32'(dch_req_cmd), 0);
      check({nm, "_dch_addr"}, dch_req_addr, 0);
      check({nm, "_dch_wdata"}, dch_req_wdata, 0);
      check({nm, "_dch_be"}, 32'(dch_req_be), 0);
      check({nm, "_dch_tag"}, 32'(dch_req_tag), 0);
      check({nm, "_stale"}, 32'(stale_cnt), 0);
      check({nm, "_busy"}, 32'(busy), 0);
      check({nm, "_req_ready"}, 32'(req_ready), 0);
   endtask

   function automatic int pick(input logic [3:0] m, input int p);
      for (int k = 0; k < NR; k++) if (m[(p + k) % NR]) return (p + k) % NR;
      return -1;
   endfunction

   // One complete transaction: grant, framer accept, response (or timeout) and strobe.
   task automatic run_txn(input vec_t v);
      int e;
      e = (v.delay < TMO) ? v.delay : TMO - 1;
      @(posedge clk); #1;
      req_valid = v.mask;
      #2;
      check("grant", 32'(req_ready), 32'(1 << v.owner));
      @(posedge clk); #1;
      req_valid     = '0;
      dch_req_ready = 1'b1;
      if (v.send_resp) begin
         dch_resp_valid  = 1'b1;
         dch_resp_tag    = v.tag;
         dch_resp_rdata  = 32'hFFFF_FFFF;
         dch_resp_status = 4'h7;
      end
      #2;
      check("send_valid", 32'(dch_req_valid), 1);
      check("send_tag", 32'(dch_req_tag), 32'(v.tag));
      check("send_cmd", 32'(dch_req_cmd), 32'(p_cmd[v.owner]));
      check("send_addr", dch_req_addr, p_addr[v.owner]);
      check("send_wdata", dch_req_wdata, p_wdata[v.owner]);
      check("send_be", 32'(dch_req_be), 32'(p_be[v.owner]));
      check("send_busy", 32'(busy), 1);
      for (int k = 0; k <= e; k++) begin
         @(posedge clk); #1;
         dch_req_ready  = 1'b0;
         dch_resp_valid = 1'b0;
         req_valid      = (k < e) ? v.mask : '0;
         if (k == v.delay) begin
            dch_resp_valid  = 1'b1;
            dch_resp_tag    = v.tag;
            dch_resp_rdata  = v.rdata;
            dch_resp_status = v.status;
         end else if (k == v.stale_at) begin
            dch_resp_valid  = 1'b1;
            dch_resp_tag    = v.tag + 8'h01;
            dch_resp_rdata  = 32'h0BAD_0BAD;
            dch_resp_status = 4'h3;
         end
         #2;
         check("wait_rsp_quiet", 32'(rsp_valid), 0);
         check("wait_dch_valid", 32'(dch_req_valid), 0);
         check("wait_ready", 32'(req_ready), 0);
         check("wait_busy", 32'(busy), 1);
      end
      @(posedge clk); #1;
      dch_resp_valid = 1'b0;
      #2;
      check("rsp_valid", 32'(rsp_valid), 32'(1 << v.owner));
      check("rsp_rdata", rsp_rdata, v.exp_rd);
      check("rsp_status", 32'(rsp_status), 32'(v.exp_st));
      check("rsp_busy", 32'(busy), 0);
      check("rsp_stale", 32'(stale_cnt), 32'(v.exp_stale));
      @(posedge clk); #3;
      check("rsp_one_cycle", 32'(rsp_valid), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int ptr_m, tag_m, stale_m, phase, wcnt, rat, owner_m, clr_g, g, n_done;
      bit pend, stale_now, match_now;
      int pown;
      logic [31:0] prd, eaddr, ewd;
      logic [3:0] pst, ecmd, ebe, exp_rdy;
      logic [7:0] etag;

      for (int i = 0; i < NR; i++) begin
         p_cmd[i]   = 4'(i % 2);
         p_addr[i]  = 32'hA000_0000 + 32'(i * 16);
         p_wdata[i] = 32'h1111_1111 * 32'(i + 1);
         p_be[i]    = 4'(15 - i);
      end
      reset_n = 1'b0; req_valid = 4'hF; dch_req_ready = 1'b0;
      dch_resp_valid = 1'b0; dch_resp_tag = '0; dch_resp_rdata = '0; dch_resp_status = '0;
      #2;
      check_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      req_valid = '0;
      reset_n   = 1'b1;

      //          mask   dly st sr rdata          sts  own tag    exp_st exp_rd        stale
      vt[0]  = '{4'b0001,  5, -1, 0, 32'hDEADBEEF, 4'h0, 0, 8'h00, 4'h0, 32'hDEADBEEF, 0};
      vt[1]  = '{4'b1111,  0, -1, 0, 32'h0000_1111, 4'h1, 1, 8'h01, 4'h1, 32'h0000_1111, 0};
      vt[2]  = '{4'b1111,  1, -1, 0, 32'h2222_0002, 4'h2, 2, 8'h02, 4'h2, 32'h2222_0002, 0};
      vt[3]  = '{4'b1111,  2, -1, 0, 32'h3333_0003, 4'h3, 3, 8'h03, 4'h3, 32'h3333_0003, 0};
      vt[4]  = '{4'b1111,  0, -1, 0, 32'h4444_0004, 4'h0, 0, 8'h04, 4'h0, 32'h4444_0004, 0};
      vt[5]  = '{4'b1010,  3, -1, 0, 32'h5555_0005, 4'h4, 1, 8'h05, 4'h4, 32'h5555_0005, 0};
      vt[6]  = '{4'b1001,  0, -1, 0, 32'h6666_0006, 4'h0, 3, 8'h06, 4'h0, 32'h6666_0006, 0};
      vt[7]  = '{4'b0100,  4, -1, 0, 32'h7777_0007, 4'h6, 2, 8'h07, 4'h6, 32'h7777_0007, 0};
      vt[8]  = '{4'b0011, 20, -1, 0, 32'h8888_0008, 4'h0, 0, 8'h08, 4'hF, 32'h0,         0};
      vt[9]  = '{4'b1000, 15, -1, 0, 32'hCAFEF00D, 4'h5, 3, 8'h09, 4'h5, 32'hCAFEF00D, 0};
      vt[10] = '{4'b0001,  3,  1, 0, 32'hA0A0_000A, 4'h0, 0, 8'h0A, 4'h0, 32'hA0A0_000A, 1};
      vt[11] = '{4'b0010,  0, -1, 1, 32'hB0B0_000B, 4'h2, 1, 8'h0B, 4'h2, 32'hB0B0_000B, 2};
      for (int i = 0; i < 12; i++) run_txn(vt[i]);

      // A response while idle is stale.
      @(posedge clk); #1;
      dch_resp_valid = 1'b1; dch_resp_tag = 8'h0C; dch_resp_rdata = 32'h1; dch_resp_status = 4'h0;
      #2;
      @(posedge clk); #1;
      dch_resp_valid = 1'b0;
      #2;
      check("idle_stale", 32'(stale_cnt), 3);
      check("idle_stale_rsp", 32'(rsp_valid), 0);

      // 256 back-to-back transactions, tag wraps through 0xFF.
      for (int i = 0; i < 256; i++) begin
         v = '{4'hF, 0, -1, 0, 32'h5A00_0000 | 32'(i), 4'(i % 15), (2 + i) % NR, 8'(12 + i),
               4'(i % 15), 32'h5A00_0000 | 32'(i), 3};
         run_txn(v);
      end

      // Asynchronous reset while waiting for a response.
      @(posedge clk); #1;
      req_valid = 4'b0001;
      #2;
      check("rw_grant", 32'(req_ready), 1);
      @(posedge clk); #1;
      req_valid = '0; dch_req_ready = 1'b1;
      #2;
      check("rw_tag", 32'(dch_req_tag), 32'h0C);
      @(posedge clk); #1;
      dch_req_ready = 1'b0; req_valid = 4'hF;
      #1;
      check("rw_busy", 32'(busy), 1);
      reset_n = 1'b0;
      #1;
      check_zero("rst_wait");
      @(posedge clk); #1;
      req_valid = '0; reset_n = 1'b1;
      #2;
      check("rw_idle", 32'(busy), 0);
      @(posedge clk); #1;
      dch_resp_valid = 1'b1; dch_resp_tag = 8'h0C; dch_resp_rdata = 32'h77; dch_resp_status = 4'h0;
      #2;
      @(posedge clk); #1;
      dch_resp_valid = 1'b0;
      #2;
      check("rw_late_stale", 32'(stale_cnt), 1);
      check("rw_late_rsp", 32'(rsp_valid), 0);
      v = '{4'hF, 2, -1, 0, 32'h1234_5678, 4'h0, 0, 8'h00, 4'h0, 32'h1234_5678, 1};
      run_txn(v);

      // Randomized traffic against a transaction-level model.
      ptr_m = 1; tag_m = 1; stale_m = 1; phase = 0; wcnt = 0; rat = 0; owner_m = 0;
      clr_g = -1; pend = 0; pown = 0; prd = '0; pst = '0; n_done = 0;
      etag = '0; ecmd = '0; eaddr = '0; ewd = '0; ebe = '0;
      for (int t = 0; t < 8000; t++) begin
         @(posedge clk); #1;
         if (clr_g >= 0) req_valid[clr_g] = 1'b0;
         clr_g = -1;
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_valid[i] = 1'b1;
               p_cmd[i]   = 4'($urandom_range(0, 1));
               p_addr[i]  = $urandom;
               p_wdata[i] = $urandom;
               p_be[i]    = 4'($urandom);
            end
         end
         dch_req_ready  = ($urandom_range(0, 2) != 0);
         dch_resp_valid = 1'b0;
         stale_now = 0; match_now = 0;
         if (phase == 2 && wcnt == rat) begin
            dch_resp_valid  = 1'b1;
            dch_resp_tag    = etag;
            dch_resp_rdata  = $urandom;
            dch_resp_status = 4'($urandom_range(0, 14));
            match_now = 1;
         end else if ($urandom_range(0, 9) == 0) begin
            dch_resp_valid  = 1'b1;
            dch_resp_tag    = (phase == 2) ? (etag ^ 8'($urandom_range(1, 255))) : 8'($urandom);
            dch_resp_rdata  = $urandom;
            dch_resp_status = 4'($urandom);
            stale_now = 1;
         end
         #2;
         check("r_rsp_valid", 32'(rsp_valid), pend ? 32'(1 << pown) : 0);
         if (pend) begin
            check("r_rsp_rdata", rsp_rdata, prd);
            check("r_rsp_status", 32'(rsp_status), 32'(pst));
         end
         check("r_busy", 32'(busy), 32'(phase != 0));
         check("r_stale", 32'(stale_cnt), 32'(stale_m));
         g = pick(req_valid, ptr_m);
         exp_rdy = (phase == 0 && g >= 0) ? 4'(1 << g) : 4'h0;
         check("r_ready", 32'(req_ready), 32'(exp_rdy));
         check("r_dch_valid", 32'(dch_req_valid), 32'(phase == 1));
         if (phase == 1) begin
            check("r_tag", 32'(dch_req_tag), 32'(etag));
            check("r_cmd", 32'(dch_req_cmd), 32'(ecmd));
            check("r_addr", dch_req_addr, eaddr);
            check("r_wdata", dch_req_wdata, ewd);
            check("r_be", 32'(dch_req_be), 32'(ebe));
         end
         pend = 0;
         if (stale_now && stale_m < 65535) stale_m++;
         if (phase == 0) begin
            if (g >= 0) begin
               owner_m = g; clr_g = g; ptr_m = (g + 1) % NR;
               etag = 8'(tag_m); ecmd = p_cmd[g]; eaddr = p_addr[g];
               ewd = p_wdata[g]; ebe = p_be[g];
               phase = 1;
            end
         end else if (phase == 1) begin
            if (dch_req_ready) begin
               tag_m = (tag_m + 1) % 256;
               phase = 2; wcnt = 0; rat = $urandom_range(0, 19);
            end
         end else begin
            if (match_now) begin
               pend = 1; pown = owner_m; prd = dch_resp_rdata; pst = dch_resp_status;
               phase = 0; n_done++;
            end else if (wcnt == TMO - 1) begin
               pend = 1; pown = owner_m; prd = '0; pst = 4'hF;
               phase = 0; n_done++;
            end else begin
               wcnt++;
            end
         end
      end
      check("r_completions", 32'(n_done >= 256), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
